// File: rtl/nn_training_control_unit_pkg.sv
// nn_cu_pkg: state encoding, output strobe bundle and default sizing for the NN training sequencer
package nn_cu_pkg;
  localparam int BIT_WIDTH_DEF    = 32;
  localparam int EXTRA_BITS_DEF   = 2;
  localparam int ERR_W            = BIT_WIDTH_DEF + EXTRA_BITS_DEF;
  localparam int NUM_UNKNOWNS_DEF = 2;
  localparam int FWD_LATENCY_DEF  = 6;
  localparam int EXTRA_CYCLES_DEF = 3;
  localparam int ITER_W_DEF       = 16;
  localparam int PH_W             = 8;
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD   = 4'd1,
    S_FWD    = 4'd2,
    S_TRAIN1 = 4'd3,
    S_TRAIN2 = 4'd4,
    S_UPDATE = 4'd5,
    S_SETTLE = 4'd6,
    S_CHECK  = 4'd7,
    S_FINISH = 4'd8,
    S_DONE   = 4'd9
  } state_t;
  typedef struct packed {
    logic training_mode;
    logic stall;
    logic init_rd;
    logic old_rd;
    logic wr_train;
    logic fin1;
    logic fin2;
    logic upd;
    logic fin;
    logic busy;
    logic done;
  } out_t;
endpackage

// File: rtl/nn_training_control_unit_if.sv
// nn_training_control_unit_if: host/datapath control bundle; master = sequencer, slave = datapath and host
interface nn_training_control_unit_if
  import nn_cu_pkg::*;
#(
  parameter int IW = ITER_W_DEF,
  parameter int EW = ERR_W
);
  logic          start;
  logic [IW-1:0] max_iter;
  logic [EW-1:0] err_threshold;
  logic [EW-1:0] Best_error;
  logic          training_mode;
  logic          stall;
  logic          local_initial_read_flag;
  logic          old_weight_rd;
  logic          local_write_training;
  logic          Finish_First_Manhattan_Iter;
  logic          Finish_Second_Manhattan_Iter;
  logic          Update_Weight;
  logic          local_finish;
  logic [IW-1:0] iter_count;
  logic          busy;
  logic          done;
  logic          converged;
  modport master (
    input  start, max_iter, err_threshold, Best_error,
    output training_mode, stall, local_initial_read_flag, old_weight_rd, local_write_training,
           Finish_First_Manhattan_Iter, Finish_Second_Manhattan_Iter, Update_Weight, local_finish,
           iter_count, busy, done, converged
  );
  modport slave (
    output start, max_iter, err_threshold, Best_error,
    input  training_mode, stall, local_initial_read_flag, old_weight_rd, local_write_training,
           Finish_First_Manhattan_Iter, Finish_Second_Manhattan_Iter, Update_Weight, local_finish,
           iter_count, busy, done, converged
  );
endinterface

// File: rtl/nn_training_control_unit_phase_counter.sv
// nn_cu_phase_counter: loadable down-counter timing each FSM phase, with current and next-cycle terminal flags
module nn_cu_phase_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc,
  output logic         last_nxt
);
  logic [W-1:0] cnt;
  always_ff @(posedge CLK) begin
    if (RESET) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign tc = cnt == '0;
  // lets the registered strobe decode flag the final cycle of a phase one cycle ahead
  assign last_nxt = load ? load_val == '0 : cnt <= W'(1);
endmodule

// File: rtl/nn_training_control_unit.sv
// nn_training_control_unit: epoch sequencer driving NN datapath strobes; NN_CU_EARLY_STOP_EN enables threshold stop
module nn_training_control_unit
  import nn_cu_pkg::*;
#(
  parameter int BIT_WIDTH    = BIT_WIDTH_DEF,
  parameter int EXTRA_BITS   = EXTRA_BITS_DEF,
  parameter int NUM_UNKNOWNS = NUM_UNKNOWNS_DEF,
  parameter int FWD_LATENCY  = FWD_LATENCY_DEF,
  parameter int Extra_Cycles = EXTRA_CYCLES_DEF,
  parameter int ITER_W       = ITER_W_DEF
) (
  input logic CLK,
  input logic RESET,
  nn_training_control_unit_if.master bus
);
  localparam int EW = BIT_WIDTH + EXTRA_BITS;
  state_t st, nxt;
  out_t o, o_q;
  logic tc, last_nxt, load, accept, hit, limit, conv_q;
  logic [PH_W-1:0] load_val;
  logic [ITER_W-1:0] iter_q, iter_inc, max_q;
  logic [EW-1:0] best;
  assign best = bus.Best_error;
  assign accept = bus.start && (st == S_IDLE || st == S_DONE);
  assign iter_inc = &iter_q ? iter_q : iter_q + ITER_W'(1);
  assign limit = iter_inc == max_q;
`ifdef NN_CU_EARLY_STOP_EN
  logic [EW-1:0] thr_q;
  always_ff @(posedge CLK) begin
    if (RESET) thr_q <= '0;
    else if (accept) thr_q <= bus.err_threshold;
  end
  assign hit = best <= thr_q;
`else
  logic unused;
  assign unused = ^{bus.err_threshold, best};
  assign hit = 1'b0;
`endif
  assign load = nxt != st;
  assign load_val = nxt == S_FWD ? PH_W'(FWD_LATENCY - 1) :
                    nxt == S_SETTLE ? PH_W'(Extra_Cycles - 1) :
                    nxt inside {S_LOAD, S_TRAIN1, S_TRAIN2, S_FINISH} ? PH_W'(NUM_UNKNOWNS - 1) : '0;
  nn_cu_phase_counter #(.W(PH_W)) u_phase (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (load),
    .load_val (load_val),
    .tc       (tc),
    .last_nxt (last_nxt)
  );
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st  <= S_IDLE;
      o_q <= '0;
    end else begin
      st  <= nxt;
      o_q <= o;
    end
  end
  always_comb begin
    nxt = st;
    case (st)
      S_IDLE, S_DONE: nxt = bus.start ? S_LOAD : st;
      S_LOAD:         nxt = tc ? S_FWD : st;
      S_FWD:          nxt = tc ? S_TRAIN1 : st;
      S_TRAIN1:       nxt = tc ? S_TRAIN2 : st;
      S_TRAIN2:       nxt = tc ? S_UPDATE : st;
      S_UPDATE:       nxt = Extra_Cycles == 0 ? S_CHECK : S_SETTLE;
      S_SETTLE:       nxt = tc ? S_CHECK : st;
      S_CHECK:        nxt = (hit || limit) ? S_FINISH : S_FWD;
      S_FINISH:       nxt = tc ? S_DONE : st;
      default:        nxt = S_IDLE;
    endcase
  end
  // strobes decode the upcoming state so they are registered alongside it
  always_comb begin
    o = '0;
    o.training_mode = nxt inside {S_LOAD, S_FWD, S_TRAIN1, S_TRAIN2, S_UPDATE, S_SETTLE, S_CHECK};
    o.stall         = nxt == S_TRAIN1 || nxt == S_TRAIN2;
    o.init_rd       = nxt == S_LOAD;
    o.old_rd        = nxt == S_TRAIN1;
    o.wr_train      = nxt == S_TRAIN2;
    o.fin1          = nxt == S_TRAIN1 && last_nxt;
    o.fin2          = nxt == S_TRAIN2 && last_nxt;
    o.upd           = nxt == S_UPDATE;
    o.fin           = nxt == S_FINISH;
    o.busy          = !(nxt inside {S_IDLE, S_DONE});
    o.done          = nxt == S_DONE;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      iter_q <= '0;
      max_q  <= '0;
      conv_q <= 1'b0;
    end else if (accept) begin
      iter_q <= '0;
      max_q  <= bus.max_iter == '0 ? ITER_W'(1) : bus.max_iter;
      conv_q <= 1'b0;
    end else if (st == S_CHECK) begin
      iter_q <= iter_inc;
      conv_q <= hit;
    end
  end
  assign bus.training_mode                = o_q.training_mode;
  assign bus.stall                        = o_q.stall;
  assign bus.local_initial_read_flag      = o_q.init_rd;
  assign bus.old_weight_rd                = o_q.old_rd;
  assign bus.local_write_training         = o_q.wr_train;
  assign bus.Finish_First_Manhattan_Iter  = o_q.fin1;
  assign bus.Finish_Second_Manhattan_Iter = o_q.fin2;
  assign bus.Update_Weight                = o_q.upd;
  assign bus.local_finish                 = o_q.fin;
  assign bus.busy                         = o_q.busy;
  assign bus.done                         = o_q.done;
  assign bus.iter_count                   = iter_q;
  assign bus.converged                    = conv_q;
endmodule

// File: tb/tb_nn_training_control_unit.sv
// tb_nn_training_control_unit: scoreboard bench; each completed run is checked when done rises
module tb_nn_training_control_unit;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;
  nn_training_control_unit_if bus ();
  nn_training_control_unit dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  int tests = 0;
  int fails = 0;
  typedef struct {
    int cyc;
    int iters;
    int conv;
  } exp_t;
  exp_t q[$];
  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [11:0] strobes();
    return {bus.training_mode, bus.stall, bus.local_initial_read_flag, bus.old_weight_rd,
            bus.local_write_training, bus.Finish_First_Manhattan_Iter, bus.Finish_Second_Manhattan_Iter,
            bus.Update_Weight, bus.local_finish, bus.busy, bus.done, bus.converged};
  endfunction
  task automatic push(input int cyc, input int iters, input int conv);
    exp_t e;
    e.cyc = cyc;
    e.iters = iters;
    e.conv = conv;
    q.push_back(e);
  endtask
  task automatic start_run(input int mi, input int thr);
    @(negedge CLK);
    bus.start = 1'b1;
    bus.max_iter = 16'(mi);
    bus.err_threshold = 34'(thr);
    @(negedge CLK);
    bus.start = 1'b0;
  endtask
  task automatic wait_done(input string name, input int limit);
    logic seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge CLK);
      seen = bus.done;
    end
    if (!seen) chk({name, "_timeout"}, seen, 1);
  endtask
  // monitor: per-run strobe tallies, compared against the scoreboard on each rising done
  initial begin
    int cyc = 0, upd = 0, f1 = 0, f2 = 0, init = 0, late = 0, stl = 0, tm = 0, fin = 0;
    logic bp = 1'b0, dp = 1'b0;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        bp = 1'b0;
        dp = 1'b0;
      end else begin
        if (bus.busy && !bp) begin
          cyc = 0; upd = 0; f1 = 0; f2 = 0; init = 0; late = 0; stl = 0; tm = 0; fin = 0;
        end else cyc++;
        upd  += int'(bus.Update_Weight);
        f1   += int'(bus.Finish_First_Manhattan_Iter);
        f2   += int'(bus.Finish_Second_Manhattan_Iter);
        init += int'(bus.local_initial_read_flag);
        late += int'(bus.local_initial_read_flag && cyc >= 2);
        stl  += int'(bus.stall);
        tm   += int'(bus.training_mode);
        fin  += int'(bus.local_finish);
        if (bus.done && !dp) begin
          if (q.size() == 0) chk("unexpected_done", q.size(), 1);
          else begin
            e = q.pop_front();
            chk("done_latency", cyc, e.cyc);
            chk("iter_count", bus.iter_count, e.iters);
            chk("converged", bus.converged, e.conv);
            chk("busy_at_done", bus.busy, 0);
            chk("update_pulses", upd, e.iters);
            chk("finish1_pulses", f1, e.iters);
            chk("finish2_pulses", f2, e.iters);
            chk("init_read_cycles", init, 2);
            chk("init_read_late", late, 0);
            chk("stall_cycles", stl, 4 * e.iters);
            chk("training_mode_cycles", tm, e.cyc - 2);
            chk("finish_cycles", fin, 2);
          end
        end
        bp = bus.busy;
        dp = bus.done;
      end
    end
  end
  initial begin
    logic seen;
    bus.start = 1'b0;
    bus.max_iter = '0;
    bus.err_threshold = '0;
    bus.Best_error = 34'h200;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_strobes", strobes(), 0);
    chk("reset_iter", bus.iter_count, 0);
    RESET = 1'b0;
    push(19, 1, 0);
    start_run(1, 0);
    wait_done("single", 100);
    push(64, 4, 0);
    start_run(4, 0);
    repeat (10) @(negedge CLK);
    bus.start = 1'b1;
    bus.max_iter = 16'd1;
    @(negedge CLK);
    bus.start = 1'b0;
    wait_done("multi", 200);
    chk("ignored_start_iter", bus.iter_count, 4);
    push(19, 1, 0);
    start_run(0, 0);
    chk("restart_clear_iter", bus.iter_count, 0);
    chk("restart_clear_done", bus.done, 0);
    wait_done("max_iter_zero", 100);
`ifdef NN_CU_EARLY_STOP_EN
    push(34, 2, 1);
`else
    push(154, 10, 0);
`endif
    start_run(10, 'h100);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      seen = bus.iter_count == 16'd1;
    end
    chk("epoch1_seen", seen, 1);
    bus.Best_error = 34'h80;
    wait_done("early_stop", 400);
    bus.Best_error = 34'h200;
    start_run(3, 0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (!bus.old_weight_rd) @(negedge CLK);
      seen = bus.old_weight_rd;
    end
    chk("train1_seen", seen, 1);
    RESET = 1'b1;
    @(negedge CLK);
    chk("midrun_reset_strobes", strobes(), 0);
    chk("midrun_reset_iter", bus.iter_count, 0);
    bus.start = 1'b1;
    bus.max_iter = 16'd2;
    @(negedge CLK);
    bus.start = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("reset_beats_start", strobes(), 0);
    push(34, 2, 0);
    start_run(2, 0);
    wait_done("recovery", 200);
    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
